// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR_ADR = 4'd10,
        S_BRANCH   = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // alu_op: how the decoder should interpret the instruction fields
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        logic [2:0] sel;
        sel = IMM_I;
        case (opcode)
            OP_STORE:          sel = IMM_S;
            OP_BRANCH:         sel = IMM_B;
            OP_JAL:            sel = IMM_J;
            OP_LUI, OP_AUIPC:  sel = IMM_U;
            default:           sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder: maps alu_op plus funct3/funct7[5] to an ALU code and
// flags funct7 combinations that have no RV32I meaning.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [3:0] alu_control_o,
    output logic       illegal_o
);

    logic r_alt;

    // funct7[5] may only be set on R-type add/sub and on either shift-right
    assign r_alt = op5_i & funct7b5_i;

    always_comb begin
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
        case (alu_op_i)
            ALUOP_ADD:   alu_control_o = ALU_ADD;
            ALUOP_SUB:   alu_control_o = ALU_SUB;
            ALUOP_PASSB: alu_control_o = ALU_PASSB;
            default: begin
                case (funct3_i)
                    3'b000: alu_control_o = r_alt ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        alu_control_o = ALU_SLL;
                        illegal_o     = funct7b5_i;
                    end
                    3'b010: begin
                        alu_control_o = ALU_SLT;
                        illegal_o     = r_alt;
                    end
                    3'b011: begin
                        alu_control_o = ALU_SLTU;
                        illegal_o     = r_alt;
                    end
                    3'b100: begin
                        alu_control_o = ALU_XOR;
                        illegal_o     = r_alt;
                    end
                    3'b101: alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: begin
                        alu_control_o = ALU_OR;
                        illegal_o     = r_alt;
                    end
                    default: begin
                        alu_control_o = ALU_AND;
                        illegal_o     = r_alt;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I Moore control unit: sequences the shared datapath through
// fetch/decode/execute/memory/write-back and traps on illegal encodings.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit FULL_BRANCH   = 1'b1,
    parameter int ALU_CTRL_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic                  zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic [3:0]            state_dbg
);

    state_t     state_q, state_d;
    logic       illegal_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       mem_ok;
    logic       br_valid;
    logic       br_taken;
    logic [1:0] alu_op;
    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7b5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // With the handshake disabled every access is treated as single-cycle
    assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (opcode[5]),
        .alu_control_o (dec_alu),
        .illegal_o     (dec_illegal)
    );

    always_comb begin
        br_valid = 1'b0;
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ: begin
                br_valid = 1'b1;
                br_taken = zero;
            end
            F3_BNE: begin
                br_valid = 1'b1;
                br_taken = ~zero;
            end
            F3_BLT: begin
                br_valid = FULL_BRANCH;
                br_taken = alu_lt;
            end
            F3_BGE: begin
                br_valid = FULL_BRANCH;
                br_taken = ~alu_lt;
            end
            F3_BLTU: begin
                br_valid = FULL_BRANCH;
                br_taken = alu_ltu;
            end
            F3_BGEU: begin
                br_valid = FULL_BRANCH;
                br_taken = ~alu_ltu;
            end
            default: begin
                br_valid = 1'b0;
                br_taken = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   state_d = dec_illegal ? S_TRAP : S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR_ADR: state_d = S_JAL;
            S_BRANCH:   state_d = br_valid ? S_FETCH : S_TRAP;
            S_LUI,
            S_AUIPC:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Moore outputs; everything is forced to its idle value while rst is high
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    ir_write   = mem_ok;
                    pc_write   = mem_ok;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR, S_JALR_ADR: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    adr_src  = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_RD2;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                end
                S_JAL: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_RD2;
                    alu_op     = ALUOP_SUB;
                    result_src = RES_ALUOUT;
                    pc_write   = br_valid & br_taken;
                end
                S_LUI: begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_PASSB;
                end
                S_AUIPC: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    assign alu_control   = ALU_CTRL_W'(dec_alu);
    assign imm_src       = rst ? IMM_I : imm_src_of(opcode);
    assign illegal_instr = illegal_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Parametrised multicycle RV32I control unit. Successor to the 5-state FETCH/DECODE/EXECUTE/MEMORY/WRITE_BACK controller.
- Moore FSM; drives datapath enables and mux selects from the IR-held instruction and ALU flags.
- Adds full RV32I base opcode coverage (LUI, AUIPC, JALR, all six branches), a variable-latency memory handshake, and illegal-opcode trapping.
- Sits between the instruction register and the shared datapath, which holds PC, OldPC, IR, ALUOut, Data, the regfile and the ALU.

Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- FULL_BRANCH, 1: 1 = BLT/BGE/BLTU/BGEU via alu_lt/alu_ltu; 0 = BEQ/BNE only, other branch funct3 values trap.
- ALU_CTRL_W, 4: alu_control width; minimum 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  IR contents
- zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2
- alu_ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR and OldPC load enable
- adr_src  out  1  0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  regfile write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = const 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB
- illegal_instr  out  1  sticky trap flag
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - rst is sampled on the clk edge and wins over every other event, including mid-wait.
  - Next state is FETCH and illegal_instr clears to 0.
  - While rst is high, all enables are 0, all selects are 0, and alu_control = add.
- Outputs are combinational from the state plus instr fields. Unlisted enables are 0 and unlisted selects are don't-care (drive 0).
- imm_src is decoded from the opcode in every state.
- FETCH:
  - Drives mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1. PC advances exactly once per fetch.
  - Stays in FETCH while mem_ready=0. When it advances, the next state is DECODE.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, add, so ALUOut = OldPC + imm.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 1100011 -> BRANCH
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> TRAP
- MEMADR: src_a=10, src_b=01, add. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: mem_read=1, adr_src=1. Waits on mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_write=1, adr_src=1. Held until mem_ready, then FETCH.
- EXEC_R and EXEC_I:
  - EXEC_R uses src_a=10, src_b=00; EXEC_I uses src_a=10, src_b=01. Both go to ALUWB.
  - alu_control comes from funct3; funct7[5] selects sub (R only) and sra (both).
  - Reserved funct7 combinations go to TRAP.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1, then ALUWB. This writes rd = OldPC + 4.
- JALR_ADR: src_a=10, src_b=01, add, then JAL. The datapath clears PC bit 0.
- BRANCH:
  - Drives src_a=10, src_b=00, sub, result_src=00.
  - pc_write = taken, where taken is:
    - BEQ: zero; BNE: !zero
    - BLT: alu_lt; BGE: !alu_lt
    - BLTU: alu_ltu; BGEU: !alu_ltu
  - Then FETCH.
- LUI: src_b=01, passB, then ALUWB.
- AUIPC: src_a=01, src_b=01, add, then ALUWB.
- TRAP: illegal_instr=1, all enables 0. Absorbing state; only rst exits.
- Latency in cycles with zero-wait memory:
  - load 5; store 4; R/I/LUI/AUIPC 4; JAL 4; JALR 5; branch 3.
  - Each wait cycle adds 1.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode localparams
  - result_src, alu_src, imm_src and alu_control encodings
  - funct3 branch codes
- Sub-module mc_alu_decoder: combinational, with inputs alu_op[1:0], funct3, funct7[5], op[5]; outputs alu_control and illegal.
- The FSM and the branch-taken logic stay in mc_control_unit.

Test Plan:
- Reset held 3 cycles mid-MEMREAD wait -> state FETCH, all enables 0, illegal_instr 0; first post-reset cycle mem_read=1.
- `add x3,x1,x2` (0x002081B3) with mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB; alu_control=0; reg_write only in cycle 4.
- `lw` with mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, mem_read=1 throughout, one reg_write pulse in MEMWB.
- `bne` with zero=1 -> pc_write=0 in BRANCH. `bltu` with alu_ltu=1 and FULL_BRANCH=1 -> pc_write=1. With FULL_BRANCH=0, `bltu` -> TRAP.
- `jalr x1,8(x5)` -> JALR_ADR, JAL, ALUWB; pc_write in JAL, reg_write in ALUWB with result_src=00.
- Opcode 0x7F -> DECODE then TRAP; illegal_instr stays 1 and no enables until rst.
